// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
//   - Command byte values recognised on the input stream.
//   - FSM state encodings (plain localparams so older tools and
//     legacy code that compares against raw codes keep working).
//   - Load target selector.
package prog_loader_pkg;

  localparam logic [7:0] CMD_LOAD_I = 8'h49;  // 'I'
  localparam logic [7:0] CMD_LOAD_D = 8'h44;  // 'D'
  localparam logic [7:0] CMD_RUN    = 8'h47;  // 'G'
  localparam logic [7:0] CMD_HALT   = 8'h48;  // 'H'

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_CNT_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;

  typedef enum logic {
    TGT_I = 1'b0,
    TGT_D = 1'b1
  } target_t;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Little-endian word assembler for the program loader.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         restart assembly at byte 0 with an empty word
//   byte_vld      a byte is being accepted this cycle
//   byte_dat      the accepted byte
//   word          assembled word (byte k lands in bits 8k+7:8k)
//   word_done     high on the cycle the last byte of a word is accepted
module loader_word_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_done
);

  logic [1:0] idx;

  // Index wraps 3 -> 0 on the last byte, so the next word starts clean
  // without an explicit clear between consecutive words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= 2'd0;
      word <= '0;
    end else if (clear) begin
      idx  <= 2'd0;
      word <= '0;
    end else if (byte_vld) begin
      word[{idx, 3'b000} +: 8] <= byte_dat;
      idx                      <= idx + 2'd1;
    end
  end

  assign word_done = byte_vld && (idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader for the rv32i_sc core.
// Receives framed bytes over valid/ready, assembles little-endian words
// and writes them to sequential word addresses of the instruction or
// data BRAM, then releases the core on a run command.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   s_dat/s_valid/s_ready  input byte stream handshake
//   w_addr, w_dat, w_byte_enb  shared BRAM write port
//   i_w_enb, d_w_enb    per-BRAM write strobes (one cycle per word)
//   d_bram_init_done    core owns the data-BRAM write port
//   pc_stall, core_rst  core hold controls (high while not running)
//   busy                a load frame is in progress
//   err                 sticky protocol error, cleared only by reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic [3:0]            w_byte_enb,
  output logic                  i_w_enb,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  err
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  logic [2:0]            state;
  target_t               tgt;
  logic [15:0]           cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready_en;
  logic                  run_q;
  logic                  err_q;
  logic                  accept;
  logic                  in_write;
  logic                  pk_clear;
  logic                  pk_vld;
  logic                  word_done;
  logic [15:0]           n_words;

  // ready_en keeps s_ready low during reset and rises on the first clock
  // after release, independently of the combinational state decode.
  assign s_ready  = ready_en && (state != ST_WRITE);
  assign accept   = s_valid && s_ready;
  assign in_write = (state == ST_WRITE);
  assign n_words  = {s_dat, cnt[7:0]};

  assign pk_clear = accept && (state == ST_IDLE) &&
                    ((s_dat == CMD_LOAD_I) || (s_dat == CMD_LOAD_D));
  assign pk_vld   = accept && (state == ST_DATA);

  loader_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .byte_vld  (pk_vld),
    .byte_dat  (s_dat),
    .word      (w_dat),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tgt      <= TGT_I;
      cnt      <= 16'd0;
      addr     <= '0;
      ready_en <= 1'b0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      // Run flags follow the state one cycle late so 'G'/'H' take effect
      // on the edge after the command is accepted, all three together.
      run_q    <= (state == ST_RUN);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (s_dat)
              CMD_LOAD_I: begin
                tgt   <= TGT_I;
                addr  <= '0;
                state <= ST_CNT_LO;
              end
              CMD_LOAD_D: begin
                tgt   <= TGT_D;
                addr  <= '0;
                state <= ST_CNT_LO;
              end
              CMD_RUN:  state <= ST_RUN;
              CMD_HALT: state <= ST_IDLE;
              default:  err_q <= 1'b1;
            endcase
          end
        end
        ST_CNT_LO: begin
          if (accept) begin
            cnt[7:0] <= s_dat;
            state    <= ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (accept) begin
            cnt[15:8] <= s_dat;
            state     <= (n_words == 16'd0) ? ST_IDLE : ST_DATA;
            // Oversized loads are flagged but still performed; the
            // address simply wraps around the BRAM.
            if ({1'b0, n_words} > MAX_N) err_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (word_done) state <= ST_WRITE;
        end
        ST_WRITE: begin
          addr  <= addr + ADDR_WIDTH'(4);
          cnt   <= cnt - 16'd1;
          state <= (cnt == 16'd1) ? ST_IDLE : ST_DATA;
        end
        ST_RUN: begin
          if (accept && (s_dat == CMD_HALT)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign w_addr           = addr;
  assign w_byte_enb       = in_write ? 4'b1111 : 4'b0000;
  assign i_w_enb          = in_write && (tgt == TGT_I);
  assign d_w_enb          = in_write && (tgt == TGT_D);
  assign d_bram_init_done = run_q;
  assign pc_stall         = !run_q;
  assign core_rst         = !run_q;
  assign busy             = (state == ST_CNT_LO) || (state == ST_CNT_HI) ||
                            (state == ST_DATA)   || (state == ST_WRITE);
  assign err              = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  s_dat;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] w_addr;
  logic [31:0] w_dat;
  logic [3:0]  w_byte_enb;
  logic        i_w_enb;
  logic        d_w_enb;
  logic        d_bram_init_done;
  logic        pc_stall;
  logic        core_rst;
  logic        busy;
  logic        err;

  int tests;
  int fails;

  prog_loader #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .MAX_WORDS  (1024)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_dat            (s_dat),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .w_addr           (w_addr),
    .w_dat            (w_dat),
    .w_byte_enb       (w_byte_enb),
    .i_w_enb          (i_w_enb),
    .d_w_enb          (d_w_enb),
    .d_bram_init_done (d_bram_init_done),
    .pc_stall         (pc_stall),
    .core_rst         (core_rst),
    .busy             (busy),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log, filled at negedges while a strobe is high.
  logic [31:0] log_dat  [0:2047];
  logic [11:0] log_addr [0:2047];
  logic [3:0]  log_be   [0:2047];
  logic        log_i    [0:2047];
  logic        log_d    [0:2047];
  int          wr_n;
  int          overlap;

  initial begin
    wr_n    = 0;
    overlap = 0;
  end

  always @(negedge clk) begin
    if (i_w_enb || d_w_enb) begin
      if (wr_n < 2048) begin
        log_dat[wr_n]  = w_dat;
        log_addr[wr_n] = w_addr;
        log_be[wr_n]   = w_byte_enb;
        log_i[wr_n]    = i_w_enb;
        log_d[wr_n]    = d_w_enb;
      end
      wr_n = wr_n + 1;
      if (s_ready) overlap = overlap + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    s_dat   = b;
    s_valid = 1'b1;
    while (!s_ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      tests++; fails++;
      $display("FAIL send_byte timeout: s_ready=%0b required 1 for byte %02h", s_ready, b);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; s_dat = 8'h00;
    repeat (3) @(negedge clk);
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    tests++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL rst_pc_stall got %b want 1", pc_stall); end
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL rst_core_rst got %b want 1", core_rst); end
    tests++; if (d_bram_init_done !== 1'b0) begin fails++; $display("FAIL rst_init_done got %b want 0", d_bram_init_done); end
    tests++; if ({i_w_enb, d_w_enb, w_byte_enb} !== 6'b0) begin fails++; $display("FAIL rst_strobes got %b want 0", {i_w_enb, d_w_enb, w_byte_enb}); end
    tests++; if (w_addr !== 12'h000 || w_dat !== 32'h0) begin fails++; $display("FAIL rst_wport got %h/%h want 000/00000000", w_addr, w_dat); end
    tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rst_busy_err got %b%b want 00", busy, err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_release_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_load_i();
    int base;
    base = wr_n;
    send_byte(8'h49);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL load_i_busy got %b want 1", busy); end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    tests++; if (i_w_enb !== 1'b1) begin fails++; $display("FAIL load_i_strobe_latency got %b want 1", i_w_enb); end
    send_byte(8'h93); send_byte(8'h02); send_byte(8'h50); send_byte(8'h00);
    repeat (3) @(negedge clk);
    tests++; if (wr_n - base !== 2) begin fails++; $display("FAIL load_i_count got %0d want 2", wr_n - base); end
    tests++; if (log_addr[base] !== 12'h000 || log_dat[base] !== 32'h00A00513) begin
      fails++; $display("FAIL load_i_w0 got %h:%h want 000:00a00513", log_addr[base], log_dat[base]); end
    tests++; if (log_addr[base+1] !== 12'h004 || log_dat[base+1] !== 32'h00500293) begin
      fails++; $display("FAIL load_i_w1 got %h:%h want 004:00500293", log_addr[base+1], log_dat[base+1]); end
    tests++; if ({log_i[base], log_d[base], log_be[base]} !== 6'b101111) begin
      fails++; $display("FAIL load_i_sel got %b want 101111", {log_i[base], log_d[base], log_be[base]}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL load_i_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_load_d_gaps();
    int base;
    logic [7:0] frame [0:6];
    base = wr_n;
    frame[0] = 8'h44; frame[1] = 8'h01; frame[2] = 8'h00; frame[3] = 8'h0A;
    frame[4] = 8'h00; frame[5] = 8'h00; frame[6] = 8'h00;
    for (int k = 0; k < 7; k++) begin
      send_byte(frame[k]);
      repeat (3) @(posedge clk);
    end
    repeat (2) @(negedge clk);
    tests++; if (wr_n - base !== 1) begin fails++; $display("FAIL load_d_count got %0d want 1", wr_n - base); end
    tests++; if (log_addr[base] !== 12'h000 || log_dat[base] !== 32'h0000000A) begin
      fails++; $display("FAIL load_d_w0 got %h:%h want 000:0000000a", log_addr[base], log_dat[base]); end
    tests++; if ({log_i[base], log_d[base]} !== 2'b01) begin
      fails++; $display("FAIL load_d_sel got i=%b d=%b want i=0 d=1", log_i[base], log_d[base]); end
  endtask

  task automatic test_run_halt();
    send_byte(8'h47);
    tests++; if ({pc_stall, core_rst, d_bram_init_done} !== 3'b110) begin
      fails++; $display("FAIL run_early got %b want 110", {pc_stall, core_rst, d_bram_init_done}); end
    @(posedge clk); #1;
    tests++; if ({pc_stall, core_rst, d_bram_init_done} !== 3'b001) begin
      fails++; $display("FAIL run_edge got %b want 001", {pc_stall, core_rst, d_bram_init_done}); end
    send_byte(8'h55);
    send_byte(8'h49);
    @(negedge clk);
    tests++; if ({err, busy, pc_stall} !== 3'b000) begin
      fails++; $display("FAIL run_ignore got err/busy/stall %b want 000", {err, busy, pc_stall}); end
    send_byte(8'h48);
    tests++; if ({pc_stall, core_rst, d_bram_init_done} !== 3'b001) begin
      fails++; $display("FAIL halt_early got %b want 001", {pc_stall, core_rst, d_bram_init_done}); end
    @(posedge clk); #1;
    tests++; if ({pc_stall, core_rst, d_bram_init_done} !== 3'b110) begin
      fails++; $display("FAIL halt_edge got %b want 110", {pc_stall, core_rst, d_bram_init_done}); end
  endtask

  task automatic test_err_zero();
    int base;
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
    base = wr_n;
    send_byte(8'h49); send_byte(8'h00); send_byte(8'h00);
    repeat (4) @(negedge clk);
    tests++; if (wr_n - base !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_count got writes=%0d busy=%b want 0/0", wr_n - base, busy); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_wrap();
    int base;
    logic [31:0] v;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    base = wr_n;
    send_byte(8'h49); send_byte(8'h01); send_byte(8'h04);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL oversize_err got %b want 1", err); end
    for (int k = 0; k < 1025; k++) begin
      v = k + 1;
      send_byte(v[7:0]); send_byte(v[15:8]); send_byte(8'h00); send_byte(8'h00);
    end
    repeat (3) @(negedge clk);
    tests++; if (wr_n - base !== 1025) begin fails++; $display("FAIL wrap_count got %0d want 1025", wr_n - base); end
    tests++; if (log_addr[base+1023] !== 12'hFFC || log_dat[base+1023] !== 32'h00000400) begin
      fails++; $display("FAIL wrap_w1023 got %h:%h want ffc:00000400", log_addr[base+1023], log_dat[base+1023]); end
    tests++; if (log_addr[base+1024] !== 12'h000 || log_dat[base+1024] !== 32'h00000401) begin
      fails++; $display("FAIL wrap_w1024 got %h:%h want 000:00000401", log_addr[base+1024], log_dat[base+1024]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wrap_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = wr_n;
    send_byte(8'h44); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk); rst = 1'b0;
    #1;
    tests++; if ({busy, err, s_ready, i_w_enb, d_w_enb} !== 5'b0) begin
      fails++; $display("FAIL mid_rst_ctl got %b want 00000", {busy, err, s_ready, i_w_enb, d_w_enb}); end
    tests++; if (w_dat !== 32'h0 || w_addr !== 12'h000 || w_byte_enb !== 4'h0) begin
      fails++; $display("FAIL mid_rst_wport got %h/%h/%h want 0/0/0", w_dat, w_addr, w_byte_enb); end
    repeat (2) @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (wr_n - base !== 0 || s_ready !== 1'b1) begin
      fails++; $display("FAIL mid_rst_nowrite got writes=%0d ready=%b want 0/1", wr_n - base, s_ready); end
    send_byte(8'h49); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (2) @(negedge clk);
    tests++; if (wr_n - base !== 1 || log_dat[base] !== 32'h44332211 || log_i[base] !== 1'b1) begin
      fails++; $display("FAIL mid_rst_fresh got n=%0d dat=%h i=%b want 1/44332211/1", wr_n - base, log_dat[base], log_i[base]); end
  endtask

  task automatic test_no_overlap();
    tests++; if (overlap !== 0) begin fails++; $display("FAIL strobe_vs_ready got %0d overlaps want 0", overlap); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; s_valid = 1'b0; s_dat = 8'h00;
    test_reset();
    test_load_i();
    test_load_d_gaps();
    test_run_halt();
    test_err_zero();
    test_wrap();
    test_reset_mid();
    test_no_overlap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
